// File: rtl/topk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : topk_pkg
// Description : Shared types and helpers for the streaming top-K selector.
//               - state_e   : frame FSM states (ACCUM, DONE)
//               - entry_w() : packed width of one list entry {valid, score, idx}
//               - sat_max() : all-ones saturation value for a given width
//               A list entry is laid out MSB->LSB as {valid, score, idx}; each
//               module declares a local packed struct with that layout, sized
//               from its own DATA_W/IDX_W parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package topk_pkg;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_e;

  function automatic int entry_w(input int data_w, input int idx_w);
    return 1 + data_w + idx_w;
  endfunction

  function automatic logic [63:0] sat_max(input int w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/topk_insert.sv
`default_nettype none
// ============================================================================
// Module      : topk_insert
// Description : Combinational insertion of one candidate into a K-entry list
//               kept sorted best-first (slot 0 = best). Pure next-list logic;
//               no state.
// Ports       : list_i        current list, K packed {valid,score,idx} entries
//               cand_score_i  candidate score (signed)
//               cand_idx_i    candidate class index
//               list_o        list after insertion
// Revision    : 1.0 - initial release
// ============================================================================
module topk_insert
  import topk_pkg::*;
#(
  parameter int K      = 3,
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4,
  localparam int ENTRY_W = entry_w(DATA_W, IDX_W)
) (
  input  logic [K*ENTRY_W-1:0]      list_i,
  input  logic signed [DATA_W-1:0]  cand_score_i,
  input  logic [IDX_W-1:0]          cand_idx_i,
  output logic [K*ENTRY_W-1:0]      list_o
);

  typedef struct packed {
    logic                     valid;
    logic signed [DATA_W-1:0] score;
    logic [IDX_W-1:0]         idx;
  } entry_t;

  entry_t [K-1:0] w_cur;
  entry_t         w_cand;
  logic   [K-1:0] w_beats;

  assign w_cur  = list_i;
  assign w_cand = {1'b1, cand_score_i, cand_idx_i};

  // The candidate always carries the highest index seen so far, so a strict
  // compare gives ties to the incumbent (lower index). Because the list is
  // sorted and valid entries are contiguous from slot 0, w_beats is a
  // thermometer code: zeros above the insertion point, ones from it down.
  for (genvar i = 0; i < K; i++) begin : g_slot
    assign w_beats[i] = !w_cur[i].valid ||
                        ($signed(cand_score_i) > $signed(w_cur[i].score));
    if (i == 0) begin : g_head
      assign list_o[ENTRY_W-1:0] = w_beats[0] ? w_cand : w_cur[0];
    end else begin : g_tail
      // Slots below the insertion point shift down by one; the last entry
      // falls off the end.
      assign list_o[i*ENTRY_W +: ENTRY_W] = w_beats[i-1] ? w_cur[i-1] :
                                            (w_beats[i] ? w_cand : w_cur[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/topk_selector.sv
`default_nettype none
// ============================================================================
// Module      : topk_selector
// Description : Streaming top-K classifier head. Accepts one signed score per
//               beat, keeps the K best (score, class index) pairs sorted, and
//               presents them with a registered valid/ready result.
// Ports       : clk, rst                      clock, async active-high reset
//               in_valid_i/in_ready_o         score beat handshake
//               in_data_i, in_last_i          score, end-of-frame marker
//               out_valid_o/out_ready_i       result handshake
//               out_idx_o, out_score_o        ranked results, slot 0 in LSBs
//               out_slot_valid_o              per-slot occupancy
//               out_len_err_o                 frame length != NUM_CLASSES
//               out_margin_o                  score[0]-score[1], saturated
//                                             (only with TOPK_MARGIN_EN)
// Config      : `define TOPK_MARGIN_EN to add the out_margin_o port.
// Revision    : 1.0 - initial release
// ============================================================================
module topk_selector
  import topk_pkg::*;
#(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 16,
  parameter int K           = 3,
  parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_W-1:0]     in_data_i,
  input  logic                  in_last_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [K*IDX_W-1:0]    out_idx_o,
  output logic [K*DATA_W-1:0]   out_score_o,
  output logic [K-1:0]          out_slot_valid_o,
  output logic                  out_len_err_o
`ifdef TOPK_MARGIN_EN
  ,
  output logic [DATA_W-1:0]     out_margin_o
`endif
);

  localparam int              ENTRY_W  = entry_w(DATA_W, IDX_W);
  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(NUM_CLASSES - 1);

  if (NUM_CLASSES < 2 || NUM_CLASSES > 256) begin : g_bad_num_classes
    $error("topk_selector: NUM_CLASSES must be in 2..256");
  end
  if (K < 1 || K > NUM_CLASSES) begin : g_bad_k
    $error("topk_selector: K must be in 1..NUM_CLASSES");
  end

  typedef struct packed {
    logic                     valid;
    logic signed [DATA_W-1:0] score;
    logic [IDX_W-1:0]         idx;
  } entry_t;

  state_e                 state_q, state_d;
  logic [K*ENTRY_W-1:0]   list_q, list_d;
  logic [IDX_W-1:0]       count_q, count_d;
  logic                   in_ready_q, in_ready_d;
  logic [K*IDX_W-1:0]     out_idx_q, out_idx_d;
  logic [K*DATA_W-1:0]    out_score_q, out_score_d;
  logic [K-1:0]           out_sv_q, out_sv_d;
  logic                   out_err_q, out_err_d;

  logic [K*ENTRY_W-1:0]   w_list_ins;
  entry_t [K-1:0]         w_ins_e;
  logic                   w_accept;
  logic                   w_at_last;
  logic                   w_frame_end;

  topk_insert #(
    .K      (K),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_insert (
    .list_i       (list_q),
    .cand_score_i (in_data_i),
    .cand_idx_i   (count_q),
    .list_o       (w_list_ins)
  );

  assign w_ins_e     = w_list_ins;
  assign w_accept    = in_valid_i && in_ready_q;
  assign w_at_last   = (count_q == LAST_CNT);
  assign w_frame_end = w_accept && (in_last_i || w_at_last);

  always_comb begin
    state_d     = state_q;
    list_d      = list_q;
    count_d     = count_q;
    in_ready_d  = in_ready_q;
    out_idx_d   = out_idx_q;
    out_score_d = out_score_q;
    out_sv_d    = out_sv_q;
    out_err_d   = out_err_q;
    unique case (state_q)
      ST_ACCUM: begin
        // in_ready is held low through reset and rises on the first edge
        // after release.
        in_ready_d = 1'b1;
        if (w_accept) begin
          list_d  = w_list_ins;
          count_d = count_q + 1'b1;
          if (w_frame_end) begin
            state_d    = ST_DONE;
            in_ready_d = 1'b0;
            // Error when the marker and the class count disagree.
            out_err_d  = in_last_i ^ w_at_last;
            for (int k = 0; k < K; k++) begin
              out_idx_d[k*IDX_W +: IDX_W]    = w_ins_e[k].valid ? w_ins_e[k].idx   : '0;
              out_score_d[k*DATA_W +: DATA_W] = w_ins_e[k].valid ? w_ins_e[k].score : '0;
              out_sv_d[k]                    = w_ins_e[k].valid;
            end
          end
        end
      end
      ST_DONE: begin
        if (out_ready_i) begin
          state_d    = ST_ACCUM;
          in_ready_d = 1'b1;
          list_d     = '0;
          count_d    = '0;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      list_q      <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_idx_q   <= '0;
      out_score_q <= '0;
      out_sv_q    <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      list_q      <= list_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_idx_q   <= out_idx_d;
      out_score_q <= out_score_d;
      out_sv_q    <= out_sv_d;
      out_err_q   <= out_err_d;
    end
  end

  assign in_ready_o       = in_ready_q;
  assign out_valid_o      = (state_q == ST_DONE);
  assign out_idx_o        = out_idx_q;
  assign out_score_o      = out_score_q;
  assign out_slot_valid_o = out_sv_q;
  assign out_len_err_o    = out_err_q;

`ifdef TOPK_MARGIN_EN
  localparam logic [DATA_W-1:0] SAT = DATA_W'(sat_max(DATA_W));

  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_margin;
  logic [DATA_W-1:0] margin_q;

  if (K < 2) begin : g_bad_margin_k
    $error("topk_selector: TOPK_MARGIN_EN requires K >= 2");
  end

  // Sign-extend by one bit so the full signed range difference fits; slot 0
  // is never below slot 1, so a set top bit can only mean overflow.
  assign w_diff   = {w_ins_e[0].score[DATA_W-1], w_ins_e[0].score} -
                    {w_ins_e[1].score[DATA_W-1], w_ins_e[1].score};
  assign w_margin = (!w_ins_e[1].valid || w_diff[DATA_W]) ? SAT : w_diff[DATA_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      margin_q <= '0;
    end else if (state_q == ST_ACCUM && w_frame_end) begin
      margin_q <= w_margin;
    end
  end

  assign out_margin_o = margin_q;
`endif

endmodule
`default_nettype wire
